mode_sequencer: RTL
===================

MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2, number of cycles each select phase is held before ready_i is sampled (legal range 1..15).
REQ-002 SHALL have parameter FIELD_W, default 4, width of the sub-code field.
REQ-003 SHALL clock all state on one clock with a synchronous active-low reset; no other clock or reset exists.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start_i  input  1  request to run one sequence.
REQ-007 abort_i  input  1  cancel the sequence in progress.
REQ-008 op_i  input  4  requested operation; [2:0] is the mode code; [3] is reserved and must be 0.
REQ-009 field_i  input  FIELD_W  sub-code delivered to the decode stage.
REQ-010 ready_i  input  1  downstream decode stage accepts the current phase.
REQ-011 mode_o  output  3  registered mode code driven to the decode stage.
REQ-012 field_o  output  FIELD_W  registered sub-code.
REQ-013 sel_o  output  1  phase select: 0 = primary operand phase, 1 = alternate operand phase.
REQ-014 valid_o  output  1  mode_o, field_o and sel_o are meaningful.
REQ-015 busy_o  output  1  high in every state except IDLE.
REQ-016 done_o  output  1  one-cycle completion pulse.
REQ-017 err_o  output  1  one-cycle error pulse.

Function
REQ-018 SHALL implement the states IDLE, LOAD, PHASE_A, PHASE_B and DONE.
REQ-019 In IDLE, start_i=1 with op_i[3]=0 SHALL capture op_i[2:0] and field_i and move to LOAD.
REQ-020 In IDLE, start_i=1 with op_i[3]=1 SHALL pulse err_o in the next cycle and stay in IDLE.
REQ-021 LOAD SHALL last exactly 1 cycle with valid_o=0, then move to PHASE_A.
REQ-022 In PHASE_A, the block SHALL drive sel_o=0 and valid_o=1 and count HOLD_CYCLES cycles.
REQ-023 When the PHASE_A count expires, the block SHALL sample ready_i: if 1, move to PHASE_B; if 0, stall with all outputs held.
REQ-024 PHASE_B SHALL behave identically to PHASE_A with sel_o=1, then move to DONE.
REQ-025 On every phase entry the hold count SHALL restart from 0.
REQ-026 The block SHALL not sample ready_i before the hold count expires.
REQ-027 DONE SHALL assert done_o for 1 cycle with valid_o=0, then return to IDLE.
REQ-028 start_i SHALL be ignored in every state other than IDLE, including DONE.
REQ-029 abort_i=1 in any non-IDLE state SHALL force IDLE next cycle with valid_o=0, done_o=0 and err_o=0.
REQ-030 abort_i=1 together with start_i=1 in IDLE SHALL keep the block in IDLE; abort wins.
REQ-031 Latency with ready_i held at 1: start_i sampled at cycle 0 gives valid_o over cycles 2..1+2*HOLD_CYCLES and done_o at cycle 2+2*HOLD_CYCLES.
REQ-032 mode_o and field_o SHALL be stable from LOAD through DONE, and SHALL be driven to 0 in IDLE.
REQ-033 The hold counter SHALL be $clog2(HOLD_CYCLES+1) bits wide and saturate at HOLD_CYCLES, never wrapping.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force IDLE and drive every output to 0, including mid-sequence and during a stall.
REQ-035 The first start_i SHALL be accepted on the first edge with rst_n=1.

Configuration
REQ-036 With PARITY_CHECK_EN defined, the block SHALL add input par_i (1 bit), the odd-parity bit over field_i, captured with start_i.
REQ-037 With PARITY_CHECK_EN defined, a parity mismatch SHALL pulse err_o during the LOAD cycle and return the block to IDLE without entering PHASE_A.
REQ-038 Without PARITY_CHECK_EN, par_i and all parity logic SHALL be absent and behaviour SHALL match REQ-018..033.

Structure
REQ-039 Package mode_seq_pkg SHALL hold the state enum, the op code constants, the HOLD_CYCLES default and the reserved-bit index.
REQ-040 Sub-module hold_counter SHALL contain the saturating phase counter, with a clear input and an expired output.

Verification
REQ-041 HOLD_CYCLES=2, ready_i=1, start_i with op=4'h5, field=4'hA at cycle 0 -> valid_o over cycles 2-5, sel_o=0 for cycles 2-3 and 1 for cycles 4-5, mode_o=3'b101, done_o at cycle 6.
REQ-042 ready_i=0 from cycle 3 to cycle 7 -> sel_o held at 0 through cycle 8, PHASE_B starts at cycle 9, done_o at cycle 11.
REQ-043 start_i with op=4'h8 -> err_o=1 for one cycle, busy_o stays 0, valid_o stays 0.
REQ-044 abort_i at cycle 4 of a running sequence -> IDLE at cycle 5 with all outputs 0 and no done_o; rst_n=0 mid-stall gives the same result.
REQ-045 PARITY_CHECK_EN defined, field=4'h3 with par_i=0 -> err_o during LOAD, return to IDLE, valid_o never asserted; with par_i=1 the sequence completes normally.

Source files
------------

// File: rtl/mode_seq_pkg.sv
// Shared types and constants for the mode sequencer: state encoding,
// op-code layout and the default phase hold length.
package mode_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_PHASE_A = 3'd2,
        ST_PHASE_B = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int HOLD_CYCLES_DEF = 2;
    localparam int FIELD_W_DEF     = 4;
    localparam int OP_W            = 4;
    localparam int MODE_W          = 3;
    localparam int OP_RSVD_BIT     = 3;

    localparam logic [MODE_W-1:0] MODE_NONE = 3'b000;

endpackage

// File: rtl/mode_sequencer_hold_counter.sv
// Saturating phase-hold counter: restarts on clear_i, counts while en_i,
// and flags expiry once the phase has been held HOLD_CYCLES cycles.
module hold_counter #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, then increment until pinned at HOLD_CYCLES.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_W'(HOLD_CYCLES))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count is 0 on the first phase cycle, so the last held cycle sees HOLD_CYCLES-1.
    assign expired_o = (cnt_q >= CNT_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/mode_sequencer.sv
// Mode sequencer: runs LOAD -> PHASE_A -> PHASE_B -> DONE per start request.
// Optional feature macro: PARITY_CHECK_EN (adds par_i odd-parity check on field_i).
module mode_sequencer
    import mode_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int FIELD_W     = FIELD_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic [FIELD_W-1:0] field_i,
`ifdef PARITY_CHECK_EN
    input  logic               par_i,
`endif
    input  logic               ready_i,
    output logic [MODE_W-1:0]  mode_o,
    output logic [FIELD_W-1:0] field_o,
    output logic               sel_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    state_e               state_q, state_d;
    logic                 capture_s;
    logic                 err_d;
    logic                 expired_s;
    logic                 in_phase_s;
    logic [MODE_W-1:0]    mode_q;
    logic [FIELD_W-1:0]   field_q;
    logic                 sel_q, valid_q, busy_q, done_q, err_q;

`ifdef PARITY_CHECK_EN
    logic par_bad_q, par_bad_d;

    function automatic logic odd_parity_ok(input logic [FIELD_W-1:0] data, input logic par);
        return ^{data, par};
    endfunction
`endif

    assign in_phase_s = (state_q == ST_PHASE_A) || (state_q == ST_PHASE_B);

    hold_counter #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_d != state_q),
        .en_i      (in_phase_s),
        .expired_o (expired_s)
    );

    // Next-state logic; abort is checked first so it beats every other request.
    always_comb begin
        state_d   = state_q;
        capture_s = 1'b0;
        err_d     = 1'b0;
`ifdef PARITY_CHECK_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (start_i && op_i[OP_RSVD_BIT]) begin
                    err_d = 1'b1;
                end else if (start_i) begin
                    state_d   = ST_LOAD;
                    capture_s = 1'b1;
`ifdef PARITY_CHECK_EN
                    par_bad_d = !odd_parity_ok(field_i, par_i);
                    err_d     = par_bad_d;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
`ifdef PARITY_CHECK_EN
                end else if (par_bad_q) begin
                    state_d = ST_IDLE;
`endif
                end else begin
                    state_d = ST_PHASE_A;
                end
            end
            ST_PHASE_A: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (expired_s && ready_i) begin
                    state_d = ST_PHASE_B;
                end else begin
                    state_d = ST_PHASE_A;
                end
            end
            ST_PHASE_B: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (expired_s && ready_i) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PHASE_B;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; outputs are decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_NONE;
            field_q <= '0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= (state_d == ST_PHASE_B);
            valid_q <= (state_d == ST_PHASE_A) || (state_d == ST_PHASE_B);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            err_q   <= err_d;
            if (state_d == ST_IDLE) begin
                mode_q  <= MODE_NONE;
                field_q <= '0;
            end else if (capture_s) begin
                mode_q  <= op_i[MODE_W-1:0];
                field_q <= field_i;
            end else begin
                mode_q  <= mode_q;
                field_q <= field_q;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    // Parity verdict captured alongside the sub-code.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_bad_q <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
        end
    end
`endif

    assign mode_o  = mode_q;
    assign field_o = field_q;
    assign sel_o   = sel_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule
